data_memory_md: RTL and testbench

- Parametrised byte-addressable data memory for the RISC-V core's load/store stage; successor to the plain word memory.
- Adds byte/half/word accesses with byte-lane writes and sign/zero-extending loads.
- Adds a valid/ready request/response handshake with backpressure, and error reporting for misaligned or out-of-range accesses.
- Single port: one request accepted per cycle at most.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/dmem_load_align.sv | 31 +++
 rtl/data_memory_md.sv | 148 ++++++++++++++
 tb/tb_data_memory_md.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the byte-addressable data memory.
// Pure combinational functions, no latency; no flow control of its own.
// Used by data_memory_md and dmem_load_align.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Illegal size is folded in here so callers need only one error term.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] wdata_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half/word lane of a memory word and sign/zero extends it.
// Purely combinational, zero latency; no flow control.
// Illegal sizes yield zero.
module dmem_load_align
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [1:0]       offset_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    output logic [WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
        data_o   = '0;
        case (size_i)
            SZ_BYTE: data_o = {{(WIDTH-8){~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{(WIDTH-16){~unsigned_i & half_sel[15]}}, half_sel};
            SZ_WORD: data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_md.sv
// Byte-addressable data memory with valid/ready request/response; optional counters via DATA_MEMORY_MD_STATS_EN.
// Latency: response registered one cycle after accept, held while rsp_ready is low.
// Backpressure: one-deep response stage, req_ready = !rsp_valid || rsp_ready.
module data_memory_md
    import mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_err
`ifdef DATA_MEMORY_MD_STATS_EN
    ,
    output logic [31:0]          stat_loads,
    output logic [31:0]          stat_stores,
    output logic [31:0]          stat_errs
`endif
);

    localparam int IDXW = ADDR_BITS - 2;
    localparam int MAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW-1:0] DEPTH_L = IDXW'(DEPTH);

    if (WIDTH != 32) begin : g_width_check
        $error("data_memory_md: WIDTH must be 32");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    rsp_state_e       state_q, state_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic [IDXW-1:0]  word_idx;
    logic [1:0]       offset;
    logic [MAW-1:0]   mem_addr;
    logic             out_of_range;
    logic             req_err;
    logic             acc;
    logic             do_store;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] load_data;

    assign word_idx     = req_addr[ADDR_BITS-1:2];
    assign offset       = req_addr[1:0];
    assign mem_addr     = word_idx[MAW-1:0];
    assign out_of_range = (word_idx >= DEPTH_L);
    assign req_err      = misaligned(req_size, offset) || out_of_range;

    assign rsp_valid = (state_q == ST_FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign acc       = req_valid && req_ready;
    assign do_store  = acc && req_we && !req_err;

    assign be      = byte_en(req_size, offset);
    assign wlanes  = wdata_lanes(req_size, req_wdata);
    assign rd_word = mem_q[mem_addr];

    dmem_load_align #(
        .WIDTH(WIDTH)
    ) u_load_align (
        .word_i    (rd_word),
        .offset_i  (offset),
        .size_i    (req_size),
        .unsigned_i(req_unsigned),
        .data_o    (load_data)
    );

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_EMPTY: if (acc) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !acc) state_d = ST_EMPTY;
        endcase
        // A new accept always overwrites the response, even when FULL (the old one is being consumed).
        if (acc) begin
            rsp_err_d   = req_err;
            rsp_rdata_d = (!req_we && !req_err) ? load_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Contents are deliberately not reset; rst only suppresses a same-cycle store.
    always_ff @(posedge clk) begin
        if (!rst && do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DATA_MEMORY_MD_STATS_EN
    logic [31:0] stat_loads_q, stat_stores_q, stat_errs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errs_q   <= '0;
        end else if (acc) begin
            if (req_err) begin
                stat_errs_q <= stat_errs_q + 32'd1;
            end else if (req_we) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end else begin
                stat_loads_q <= stat_loads_q + 32'd1;
            end
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_data_memory_md.sv
// Scoreboard bench for data_memory_md: directed requests push expected responses, a monitor pops and compares.
module tb_data_memory_md;
    import mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int WIDTH = 32;
    localparam int AB    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AB-1:0]    req_addr;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
`ifdef DATA_MEMORY_MD_STATS_EN
    logic [31:0]      stat_loads, stat_stores, stat_errs;
`endif

    always #5 clk = ~clk;

    data_memory_md #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
`ifdef DATA_MEMORY_MD_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stamp;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 2ns after the falling edge, i.e. the state the next rising edge will act on.
    always begin
        @(negedge clk);
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with empty scoreboard", rsp_rdata, rsp_err);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                if (mon_e.lat) check("rsp_latency", 32'(cyc - mon_e.stamp), 32'd1);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        int  waited = 0;
        bit  done   = 0;
        logic acc;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        while (!done) begin
            #1;
            acc = req_ready;
            @(posedge clk);
            if (acc) begin
                sb.push_back('{er, ee, cyc, 1'b1});
                done = 1;
            end else begin
                waited++;
                if (waited > 20) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL issue_timeout: got no accept for addr 0x%08h, required accept within 20 cycles", addr);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before 500000");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);

        // word store / load round trip
        issue(1, 32'h10, SZ_WORD, 0, 32'hDEAD_BEEF, 32'h0, 0);
        issue(0, 32'h10, SZ_WORD, 0, 32'h0, 32'hDEAD_BEEF, 0);

        // byte lane write and extension
        issue(1, 32'h10, SZ_WORD, 0, 32'h0000_0000, 32'h0, 0);
        issue(1, 32'h13, SZ_BYTE, 0, 32'h1234_5680, 32'h0, 0);
        issue(0, 32'h13, SZ_BYTE, 0, 32'h0, 32'hFFFF_FF80, 0);
        issue(0, 32'h13, SZ_BYTE, 1, 32'h0, 32'h0000_0080, 0);
        issue(0, 32'h10, SZ_WORD, 0, 32'h0, 32'h8000_0000, 0);

        // half accesses and error cases
        issue(1, 32'h20, SZ_WORD, 0, 32'h1122_3344, 32'h0, 0);
        issue(1, 32'h21, SZ_HALF, 0, 32'h0000_FFFF, 32'h0, 1);
        issue(0, 32'h20, SZ_WORD, 0, 32'h0, 32'h1122_3344, 0);
        issue(1, 32'h22, SZ_HALF, 0, 32'h5555_AABB, 32'h0, 0);
        issue(0, 32'h22, SZ_HALF, 0, 32'h0, 32'hFFFF_AABB, 0);
        issue(0, 32'h22, SZ_HALF, 1, 32'h0, 32'h0000_AABB, 0);
        issue(0, 32'h20, SZ_HALF, 0, 32'h0, 32'h0000_3344, 0);
        issue(0, 32'h21, SZ_BYTE, 1, 32'h0, 32'h0000_0033, 0);
        issue(0, 32'h20, SZ_ILL,  0, 32'h0, 32'h0, 1);
        issue(0, 32'h22, SZ_WORD, 0, 32'h0, 32'h0, 1);
        issue(0, DEPTH * 4, SZ_WORD, 0, 32'h0, 32'h0, 1);
        issue(1, 32'h0,  SZ_WORD, 0, 32'h0102_0304, 32'h0, 0);
        issue(1, DEPTH * 4, SZ_WORD, 0, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 32'h0,  SZ_WORD, 0, 32'h0, 32'h0102_0304, 0);
        issue(0, 32'h20, SZ_WORD, 1, 32'h0, 32'hAABB_3344, 0);

        // junk store inputs with req_valid low must do nothing
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_size  = SZ_WORD;
        req_wdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        issue(0, 32'h20, SZ_WORD, 0, 32'h0, 32'hAABB_3344, 0);
        drain();

        // backpressure: hold rsp_ready low for 3 cycles
        @(negedge clk);
        rsp_ready    = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h10;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        #1;
        check("stall_first_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        sb.push_back('{32'h8000_0000, 1'b0, cyc, 1'b0});
        @(negedge clk);
        req_addr = 32'h20;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_rsp_rdata", rsp_rdata, 32'h8000_0000);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("unstall_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        sb.push_back('{32'hAABB_3344, 1'b0, cyc, 1'b1});
        drain();

        // stream 8 stores then 8 loads back to back
        for (int i = 0; i < 8; i++)
            issue(1, 32'h40 + 4 * i, SZ_WORD, 0, 32'hA500_0000 + i, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            issue(0, 32'h40 + 4 * i, SZ_WORD, 0, 32'h0, 32'hA500_0000 + i, 0);

        // reset mid-stream: pending load response dropped, same-cycle store suppressed
        issue(0, 32'h44, SZ_WORD, 0, 32'h0, 32'hA500_0001, 0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_size  = SZ_WORD;
        req_wdata = 32'hFFFF_FFFF;
        #1;
        check("rst_pending_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        @(posedge clk);
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        issue(0, 32'h40, SZ_WORD, 0, 32'h0, 32'hA500_0000, 0);
        drain();

`ifdef DATA_MEMORY_MD_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            issue(0, 32'h40 + 4 * i, SZ_WORD, 0, 32'h0, 32'hA500_0000 + i, 0);
        for (int i = 0; i < 3; i++)
            issue(1, 32'h60 + 4 * i, SZ_WORD, 0, 32'h1000 + i, 32'h0, 0);
        issue(0, 32'h41, SZ_HALF, 0, 32'h0, 32'h0, 1);
        issue(1, DEPTH * 4, SZ_BYTE, 0, 32'h0, 32'h0, 1);
        drain();
        check("stat_loads", stat_loads, 32'd5);
        check("stat_stores", stat_stores, 32'd3);
        check("stat_errs", stat_errs, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stat_loads_rst", stat_loads, 32'd0);
        check("stat_stores_rst", stat_stores, 32'd0);
        check("stat_errs_rst", stat_errs, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
